// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults for the processor memory interface.
package mem_pkg;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int MAX_READ_LAT = 4;
endpackage

// File: rtl/rd_pipe.sv
// rd_pipe: LAT-deep {valid, data} return pipeline with synchronous clear.
module rd_pipe
  import mem_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  if (LAT < 1 || LAT > MAX_READ_LAT) begin : g_bad_lat
    $error("rd_pipe: LAT out of range");
  end
  logic [LAT-1:0]    v;
  logic [DATA_W-1:0] d [LAT];
  // Data only advances alongside a valid token, so the last stage holds the most recent returned word.
  always_ff @(posedge clk) begin
    if (clr) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];
endmodule

// File: rtl/dram_responder.sv
// dram_responder: word memory answering processor RD/WR strobes with fixed read latency.
// Define DRAM_RESPONDER_STATS_EN to add saturating RdCount/WrCount outputs.
module dram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 65536,
  parameter int READ_LAT = 2
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              RD,
  input  logic              WR,
  output logic [DATA_W-1:0] DataOut,
  output logic              Valid,
  output logic              Err
`ifdef DRAM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       RdCount,
  output logic [31:0]       WrCount
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx;
  logic              do_rd, do_wr;
  assign idx   = AW'(Addr % (ADDR_W+1)'(DEPTH));
  assign do_wr = WR & ~Reset;
  assign do_rd = RD & ~WR & ~Reset;
  always_ff @(posedge Clk1) begin
    if (do_wr) mem[idx] <= DataIn;
  end
  always_ff @(posedge Clk1) begin
    Err <= RD & WR & ~Reset;
  end
  // Memory is read at the request edge, so writes from earlier edges are already visible.
  rd_pipe #(.LAT(READ_LAT), .DATA_W(DATA_W)) u_pipe (
    .clk      (Clk1),
    .clr      (Reset),
    .in_valid (do_rd),
    .in_data  (mem[idx]),
    .out_valid(Valid),
    .out_data (DataOut)
  );
`ifdef DRAM_RESPONDER_STATS_EN
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      RdCount <= '0;
      WrCount <= '0;
    end else begin
      if (do_rd && ~&RdCount) RdCount <= RdCount + 32'd1;
      if (do_wr && ~&WrCount) WrCount <= WrCount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: scoreboard bench for dram_responder (DEPTH=1024, READ_LAT=2, plus a READ_LAT=4 copy for reset flush).
module tb_dram_responder;
  localparam int LAT = 2;
  typedef struct { logic [15:0] d; int c; } exp_t;
  logic clk = 0, rst = 1, rd = 0, wr = 0;
  logic [15:0] addr = '0, din = '0;
  logic [15:0] dout, dout4;
  logic valid, err, valid4, err4;
`ifdef DRAM_RESPONDER_STATS_EN
  logic [31:0] rdc, wrc, rdc4, wrc4;
`endif
  int ntests = 0, nfail = 0, cyc = 0, err_cyc = -1, vcount = 0;
  bit mon_en = 0;
  exp_t q[$];
  logic [15:0] mdl [1024];
  logic [15:0] last_data = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dram_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .READ_LAT(LAT)) u_dut (
    .Clk1(clk), .Reset(rst), .Addr(addr), .DataIn(din), .RD(rd), .WR(wr),
    .DataOut(dout), .Valid(valid), .Err(err)
`ifdef DRAM_RESPONDER_STATS_EN
    , .RdCount(rdc), .WrCount(wrc)
`endif
  );
  dram_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .READ_LAT(4)) u_dut4 (
    .Clk1(clk), .Reset(rst), .Addr(addr), .DataIn(din), .RD(rd), .WR(wr),
    .DataOut(dout4), .Valid(valid4), .Err(err4)
`ifdef DRAM_RESPONDER_STATS_EN
    , .RdCount(rdc4), .WrCount(wrc4)
`endif
  );
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      ntests++;
      if (err !== (cyc == err_cyc)) begin
        nfail++;
        $display("FAIL err: got %b want %b at cycle %0d", err, cyc == err_cyc, cyc);
      end
      ntests++;
      if (valid === 1'b1) begin
        vcount++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL valid: unexpected read data %h at cycle %0d", dout, cyc);
        end else begin
          e = q.pop_front();
          last_data = e.d;
          if (dout !== e.d || cyc != e.c) begin
            nfail++;
            $display("FAIL read: got %h at cycle %0d want %h at cycle %0d", dout, cyc, e.d, e.c);
          end
        end
      end else if (valid !== 1'b0 || dout !== last_data) begin
        nfail++;
        $display("FAIL hold: valid %b dout %h want valid 0 dout %h at cycle %0d", valid, dout, last_data, cyc);
      end
    end
  end
  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; din = d;
    if (r && !w) q.push_back('{mdl[a[9:0]], cyc + LAT});
    if (r && w) err_cyc = cyc + 1;
    if (w) mdl[a[9:0]] = d;
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    q.delete(); last_data = '0; err_cyc = -1;
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    idle(2);
    ntests++;
    if (valid !== 1'b0 || dout !== 16'h0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL reset: valid %b dout %h err %b want 0 0000 0", valid, dout, err);
    end
    rst = 0; mon_en = 1;
  endtask
  task automatic test_basic();
    int v0;
    drive(0, 1, 16'h0010, 16'hBEEF);
    v0 = vcount;
    drive(1, 0, 16'h0010, 16'h0);
    idle(LAT + 1);
    ntests++;
    if (vcount - v0 != 1 || last_data !== 16'hBEEF) begin
      nfail++;
      $display("FAIL basic: %0d returns last %h want 1 returns BEEF", vcount - v0, last_data);
    end
  endtask
  task automatic test_raw();
    drive(0, 1, 16'h0005, 16'h1111);
    idle(1);
    drive(0, 1, 16'h0005, 16'h1234);
    drive(1, 0, 16'h0005, 16'h0);
    idle(LAT + 1);
    ntests++;
    if (last_data !== 16'h1234) begin
      nfail++;
      $display("FAIL raw: got %h want 1234", last_data);
    end
  endtask
  task automatic test_back_to_back();
    int v0;
    for (int i = 0; i < 16; i++) drive(0, 1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    v0 = vcount;
    for (int i = 0; i < 16; i++) drive(1, 0, 16'h0100 + 16'(i), 16'h0);
    idle(LAT + 2);
    ntests++;
    if (vcount - v0 != 16 || last_data !== 16'hA00F) begin
      nfail++;
      $display("FAIL back_to_back: %0d returns last %h want 16 returns A00F", vcount - v0, last_data);
    end
  endtask
  task automatic test_collision();
    int v0;
    v0 = vcount;
    drive(1, 1, 16'h0020, 16'h5555);
    idle(LAT + 2);
    ntests++;
    if (vcount != v0) begin
      nfail++;
      $display("FAIL collision_valid: %0d returns want 0", vcount - v0);
    end
    drive(1, 0, 16'h0020, 16'h0);
    idle(LAT + 1);
    ntests++;
    if (last_data !== 16'h5555) begin
      nfail++;
      $display("FAIL collision_data: got %h want 5555", last_data);
    end
  endtask
  task automatic test_reset_flush();
    int hits = 0;
    drive(0, 1, 16'h0033, 16'hCAFE);
    idle(6);
    for (int i = 0; i < 3; i++) drive(1, 0, 16'h0100 + 16'(i), 16'h0);
    rst = 1; rd = 1; wr = 1; addr = 16'h0033; din = 16'h0BAD;
    @(posedge clk); #1;
    q.delete(); last_data = '0; err_cyc = -1;
    rst = 0; rd = 0; wr = 0;
    ntests++;
    if (dout !== 16'h0 || dout4 !== 16'h0) begin
      nfail++;
      $display("FAIL flush_data: dout %h dout4 %h want 0000 0000", dout, dout4);
    end
    repeat (8) begin
      @(negedge clk);
      if (valid4 !== 1'b0) hits++;
    end
    @(posedge clk); #1;
    ntests++;
    if (hits != 0 || dout4 !== 16'h0) begin
      nfail++;
      $display("FAIL flush_valid4: %0d valid cycles dout4 %h want 0 0000", hits, dout4);
    end
    drive(1, 0, 16'h0033, 16'h0);
    idle(LAT + 1);
    ntests++;
    if (last_data !== 16'hCAFE) begin
      nfail++;
      $display("FAIL flush_mem: got %h want CAFE", last_data);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    drive(0, 1, 16'h0403, 16'h7777);
    drive(1, 0, 16'h0003, 16'h0);
    idle(LAT + 1);
    ntests++;
    if (last_data !== 16'h7777) begin
      nfail++;
      $display("FAIL wrap: got %h want 7777", last_data);
    end
`ifdef DRAM_RESPONDER_STATS_EN
    ntests++;
    if (rdc !== 32'd1 || wrc !== 32'd1) begin
      nfail++;
      $display("FAIL stats: rd %0d wr %0d want 1 1", rdc, wrc);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_back_to_back();
    test_collision();
    test_reset_flush();
    test_wrap();
    idle(8);
    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d reads never returned want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
